unified_mem_arbiter: RTL and testbench

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/unified_mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one memory port between an instruction-fetch and a data requester.
// Alternating priority after a data grant, a per-transaction wait timeout, and one-cycle ready pulses.
module unified_mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        bus_err
);

  localparam int         REQ_IF    = 0;
  localparam int         REQ_DM    = 1;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_DM = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        last_dm_q, last_dm_d;

  logic        mem_we_q;
  logic [2:0]  mem_size_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        bus_err_q;

  logic [1:0]  ready_q, ready_d;
  logic [31:0] rdata_q [2];
  logic [31:0] rdata_d [2];

  logic [1:0]  sel_vec;
  logic [1:0]  keep_rdata;
  logic        busy;
  logic        grant_go;
  logic        grant_dm;
  logic        resp_hold;
  logic        complete;
  logic        abort;
  logic [7:0]  wait_inc;

  // A timeout returns straight to IDLE while the ready pulse is still out;
  // the requester's req is still high then, so hold off granting for that cycle.
  assign resp_hold = |ready_q;
  assign grant_dm  = dm_req & ~(last_dm_q & if_req);
  assign grant_go  = (state_q == S_IDLE) & (if_req | dm_req) & ~resp_hold;
  assign wait_inc  = wait_q + 8'd1;
  assign complete  = busy & mem_ready;
  assign abort     = busy & ~mem_ready & (wait_inc == TIMEOUT_C);

  // Stores must not disturb the last load result.
  assign keep_rdata = {mem_we_q, 1'b0};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      last_dm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      last_dm_q <= last_dm_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    last_dm_d = last_dm_q;
    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (grant_go) begin
          state_d = grant_dm ? S_BUSY_DM : S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_DM: begin
        if (mem_ready) begin
          state_d   = S_RESP;
          last_dm_d = (state_q == S_BUSY_DM);
        end else begin
          wait_d = wait_inc;
          if (abort) begin
            state_d   = S_IDLE;
            last_dm_d = (state_q == S_BUSY_DM);
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state
  always_comb begin
    busy    = 1'b0;
    sel_vec = '0;
    case (state_q)
      S_BUSY_IF: begin
        busy            = 1'b1;
        sel_vec[REQ_IF] = 1'b1;
      end
      S_BUSY_DM: begin
        busy            = 1'b1;
        sel_vec[REQ_DM] = 1'b1;
      end
      default: begin
        busy    = 1'b0;
        sel_vec = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign ready_d[gi] = sel_vec[gi] & (complete | abort);
      assign rdata_d[gi] = (sel_vec[gi] & ~keep_rdata[gi] & complete) ? mem_rdata :
                           (sel_vec[gi] & ~keep_rdata[gi] & abort)    ? 32'd0     :
                                                                        rdata_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= '0;
      rdata_q <= '{default: '0};
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields are captured once at grant so the requester may change them afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      bus_err_q <= abort;
      if (grant_go) begin
        if (grant_dm) begin
          mem_we_q    <= dm_we;
          mem_size_q  <= dm_size;
          mem_addr_q  <= dm_addr;
          mem_wdata_q <= dm_wdata;
        end else begin
          mem_we_q    <= 1'b0;
          mem_size_q  <= 3'b010;
          mem_addr_q  <= if_addr;
          mem_wdata_q <= '0;
        end
      end
    end
  end

  assign mem_req   = busy;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_err   = bus_err_q;
  assign if_ready  = ready_q[REQ_IF];
  assign dm_ready  = ready_q[REQ_DM];
  assign if_rdata  = rdata_q[REQ_IF];
  assign dm_rdata  = rdata_q[REQ_DM];
  assign stall     = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a memory responder with configurable wait,
// and a scoreboard of expected completions checked whenever a ready pulse appears.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [2:0]  dm_size;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        bus_err;

  typedef struct {
    bit          dm;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   fails   = 0;
  int   mem_wait = 0;
  bit   spurious = 0;
  int   dm_done;
  int   if_done;

  unified_mem_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    if (addr == 32'h10) return 32'h0050_0093;
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input bit dm, input logic [31:0] rd, input bit err);
    exp_t e;
    e.dm = dm; e.rdata = rd; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Keep requests up until their ready is seen, then drop them.
  task automatic run(input int budget);
    int n = 0;
    while ((if_req || dm_req) && n < budget) begin
      tick();
      if (if_ready) if_req = 1'b0;
      if (dm_ready) dm_req = 1'b0;
      n++;
    end
    chk("run_budget", {30'd0, if_req, dm_req}, 32'd0);
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    tick();
  endtask

  // Memory model: answers after mem_wait cycles of mem_req, never if mem_wait < 0.
  initial begin
    int cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (mem_wait >= 0 && cnt == mem_wait) begin
          mem_ready = 1'b1;
          mem_rdata = mem_model(mem_addr);
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hBAD0_0000;
        end
        cnt++;
      end else begin
        cnt = 0;
        mem_ready = spurious;
        mem_rdata = 32'hBAD0_0000;
      end
    end
  end

  // Scoreboard consumer: every ready pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && (if_ready || dm_ready)) begin
      chk("ready_onehot", {31'd0, if_ready & dm_ready}, 32'd0);
      vectors++;
      assert (sb_q.size() != 0) else begin
        fails++;
        $error("FAIL sb_unexpected: got ready if=%0b dm=%0b, expected no ready", if_ready, dm_ready);
      end
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("sb_who", {31'd0, dm_ready}, {31'd0, mon_e.dm});
        chk("sb_rdata", dm_ready ? dm_rdata : if_rdata, mon_e.rdata);
        chk("sb_err", {31'd0, bus_err}, {31'd0, mon_e.err});
        $display("txn %s rdata=%h err=%0b", dm_ready ? "DM" : "IF",
                 dm_ready ? dm_rdata : if_rdata, bus_err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
    dm_size = '0; dm_addr = '0; dm_wdata = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_readies", {29'd0, if_ready, dm_ready, bus_err}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    tick();

    // Fetch with zero wait: ready two cycles after the request is seen
    if_req = 1'b1; if_addr = 32'h10;
    push(1'b0, 32'h0050_0093, 1'b0);
    tick();
    chk("f_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h10);
    tick();
    chk("f_if_ready", {31'd0, if_ready}, 32'd1);
    chk("f_if_rdata", if_rdata, 32'h0050_0093);
    if_req = 1'b0;
    tick();
    chk("f_after", {30'd0, if_ready, mem_req}, 32'd0);
    tick();

    // Simultaneous requests after a fetch grant: data first, stall held until fetch ready
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_size = 3'd4;
    push(1'b1, mem_model(32'h200), 1'b0);
    push(1'b0, mem_model(32'h20), 1'b0);
    for (int c = 0; c < 40 && if_req; c++) begin
      tick();
      if (if_ready) begin
        if_req = 1'b0;
      end else begin
        chk("sim_stall", {31'd0, stall}, 32'd1);
        if (dm_ready) dm_req = 1'b0;
      end
    end
    chk("sim_stall_end", {30'd0, stall, if_req}, 32'd0);
    tick(); tick();

    // Back-to-back data with fetch held: DM, IF, DM, IF
    dm_done = 0; if_done = 0;
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    push(1'b1, mem_model(32'h300), 1'b0);
    push(1'b0, mem_model(32'h40), 1'b0);
    for (int c = 0; c < 60 && (if_req || dm_req); c++) begin
      tick();
      if (dm_ready) begin
        dm_done++;
        if (dm_done < 2) begin
          dm_addr = 32'h304;
          push(1'b1, mem_model(32'h304), 1'b0);
        end else begin
          dm_req = 1'b0;
        end
      end
      if (if_ready) begin
        if_done++;
        if (if_done < 2) push(1'b0, mem_model(32'h40), 1'b0);
        else if_req = 1'b0;
      end
    end
    chk("alt_counts", {16'(dm_done), 16'(if_done)}, {16'd2, 16'd2});
    tick(); tick();

    // Store with two wait cycles: fields forwarded, dm_rdata keeps the last load
    mem_wait = 2;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_size = 3'd2;
    push(1'b1, mem_model(32'h304), 1'b0);
    tick();
    chk("st_mem_req", {31'd0, mem_req}, 32'd1);
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_addr", mem_addr, 32'h100);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_mem_size", {29'd0, mem_size}, 32'd2);
    run(20);

    // Requester drops req mid-transaction: ready still issued
    mem_wait = 1; dm_we = 1'b0;
    if_req = 1'b1; if_addr = 32'h60;
    push(1'b0, mem_model(32'h60), 1'b0);
    tick();
    if_req = 1'b0;
    repeat (4) tick();
    chk("drop_sb", sb_q.size(), 32'd0);

    // Memory never answers: abort after 15 busy cycles
    mem_wait = -1;
    if_req = 1'b1; if_addr = 32'h80;
    push(1'b0, 32'd0, 1'b1);
    tick();
    chk("to_busy1", {29'd0, bus_err, if_ready, mem_req}, 32'b001);
    for (int k = 2; k <= 15; k++) begin
      tick();
      chk("to_busy", {29'd0, bus_err, if_ready, mem_req}, 32'b001);
    end
    tick();
    chk("to_abort", {29'd0, bus_err, if_ready, mem_req}, 32'b110);
    chk("to_rdata", if_rdata, 32'd0);
    if_req = 1'b0;
    tick();
    chk("to_idle", {29'd0, bus_err, if_ready, mem_req}, 32'b000);
    tick();
    chk("to_no_regrant", {31'd0, mem_req}, 32'd0);

    // mem_ready outside BUSY is ignored
    spurious = 1'b1;
    repeat (3) tick();
    chk("spur_idle", {29'd0, if_ready, dm_ready, mem_req}, 32'd0);
    spurious = 1'b0;
    tick();

    // Reset in the third busy cycle abandons the store
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h400; dm_wdata = 32'hCAFE_F00D; dm_size = 3'd1;
    repeat (3) tick();
    chk("rb_busy3", {31'd0, mem_req}, 32'd1);
    rst = 1'b1; dm_req = 1'b0;
    tick();
    chk("rb_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rb_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rb_mem_addr", mem_addr, 32'd0);
    chk("rb_mem_wdata", mem_wdata, 32'd0);
    chk("rb_mem_size", {29'd0, mem_size}, 32'd0);
    chk("rb_readies", {29'd0, if_ready, dm_ready, bus_err}, 32'd0);
    chk("rb_dm_rdata", dm_rdata, 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("rb_quiet", {29'd0, if_ready, dm_ready, mem_req}, 32'd0);

    // Normal service after reset; cleared last-grant flag lets data win
    mem_wait = 0;
    if_req = 1'b1; if_addr = 32'h24;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    push(1'b1, mem_model(32'h500), 1'b0);
    push(1'b0, mem_model(32'h24), 1'b0);
    run(30);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
